// File: rtl/timer_pkg.sv
// Shared definitions for the time-keeping core: FSM and direction encodings,
// field limits, the {hh,mm,ss} layout and the carry/borrow/clamp helpers.
package timer_pkg;

    localparam int FIELD_W = 8;
    localparam int BUS_W   = 3 * FIELD_W;

    localparam int HH_LSB = 16;
    localparam int MM_LSB = 8;
    localparam int SS_LSB = 0;

    localparam logic [FIELD_W-1:0] SEC_MAX = 8'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX = 8'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } timer_dir_t;

    // Packed so that the struct maps directly onto bus[23:0] = {hh,mm,ss}.
    typedef struct packed {
        logic [FIELD_W-1:0] hh;
        logic [FIELD_W-1:0] mm;
        logic [FIELD_W-1:0] ss;
    } hms_t;

    function automatic hms_t clamp_time(input hms_t t, input logic [FIELD_W-1:0] hour_max);
        hms_t r;
        r = t;
        if (t.ss > SEC_MAX)  r.ss = SEC_MAX;
        if (t.mm > MIN_MAX)  r.mm = MIN_MAX;
        if (t.hh > hour_max) r.hh = hour_max;
        return r;
    endfunction

    function automatic hms_t time_inc(input hms_t t, input logic [FIELD_W-1:0] hour_max);
        hms_t r;
        r = t;
        if (t.ss < SEC_MAX) begin
            r.ss = t.ss + 8'd1;
        end else begin
            r.ss = '0;
            if (t.mm < MIN_MAX) begin
                r.mm = t.mm + 8'd1;
            end else begin
                r.mm = '0;
                r.hh = (t.hh < hour_max) ? t.hh + 8'd1 : '0;
            end
        end
        return r;
    endfunction

    // Saturates at 00:00:00 so a stray call can never roll the timer backwards.
    function automatic hms_t time_dec(input hms_t t);
        hms_t r;
        r = t;
        if (t != '0) begin
            if (t.ss != '0) begin
                r.ss = t.ss - 8'd1;
            end else begin
                r.ss = SEC_MAX;
                if (t.mm != '0) begin
                    r.mm = t.mm - 8'd1;
                end else begin
                    r.mm = MIN_MAX;
                    r.hh = t.hh - 8'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Control/data bundle between the time-keeping core and its surroundings
// (button logic on the master side, display scanner reading bus/done/tick).
interface time_counter_if;
    import timer_pkg::*;

    logic             start;
    logic             mode;
    logic             load;
    logic [BUS_W-1:0] load_val;
    logic [BUS_W-1:0] bus;
    logic             done;
    logic             tick;

    modport master (
        output start, mode, load, load_val,
        input  bus, done, tick
    );

    modport slave (
        input  start, mode, load, load_val,
        output bus, done, tick
    );

endinterface

// File: rtl/time_tick_gen.sv
// Seconds prescaler: counts enabled clock cycles and strobes tick on the last
// cycle of each second; holds its fraction while disabled.
module time_tick_gen #(
    parameter int CLK_HZ = 1000
) (
    input  logic clk1000,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Combinational strobe; the parent registers it together with the time update.
    assign tick = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/time_counter.sv
// Hours/minutes/seconds core: run/pause/done FSM plus the up/down carry chain,
// presenting {hh,mm,ss} in binary to the display stage.
module time_counter
    import timer_pkg::*;
#(
    parameter int CLK_HZ   = 1000,
    parameter int HOUR_MAX = 23
) (
    input  logic           clk1000,
    input  logic           rst,
    time_counter_if.slave  tif
);

    localparam logic [FIELD_W-1:0] HOUR_LAST = FIELD_W'(HOUR_MAX);

    timer_state_t state;
    timer_dir_t   dir;
    hms_t         now;
    logic         tick_q;
    logic         done_q;

    logic         sec_tick;
    logic         run_en;
    hms_t         now_up;
    hms_t         now_down;
    hms_t         load_clamped;
    logic         hit_zero;

    assign run_en = (state == RUN);

    time_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk1000 (clk1000),
        .rst     (rst),
        .en      (run_en),
        .clr     (tif.load),
        .tick    (sec_tick)
    );

    assign now_up       = time_inc(now, HOUR_LAST);
    assign now_down     = time_dec(now);
    assign load_clamped = clamp_time(hms_t'(tif.load_val), HOUR_LAST);
    assign hit_zero     = sec_tick && (dir == DIR_DOWN) && (now_down == '0);

    // Load overrides everything; reaching zero wins over a pause request in the same cycle.
    always_ff @(posedge clk1000 or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dir    <= DIR_UP;
            now    <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (tif.load) begin
                now    <= load_clamped;
                state  <= IDLE;
                done_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tif.start) begin
                            dir <= timer_dir_t'(tif.mode);
                            if (tif.mode && (now == '0)) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (sec_tick) begin
                            tick_q <= 1'b1;
                            now    <= (dir == DIR_UP) ? now_up : now_down;
                        end
                        if (hit_zero) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (tif.start) begin
                            state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (tif.start) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        if (tif.start) begin
                            state  <= IDLE;
                            done_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tif.bus  = now;
    assign tif.done = done_q;
    assign tif.tick = tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: reset, up wrap, down-to-zero, pause/resume,
// load clamp/priority and asynchronous reset mid-run.
module tb_time_counter;
    import timer_pkg::*;

    logic clk1000 = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;
    int ticks;
    int first_tick;

    time_counter_if tif();

    time_counter #(
        .CLK_HZ   (1000),
        .HOUR_MAX (23)
    ) dut (
        .clk1000 (clk1000),
        .rst     (rst),
        .tif     (tif.slave)
    );

    always #5 clk1000 = ~clk1000;

    // Every step lands 1 ns after the rising edge, which is where inputs change and outputs are sampled.
    task automatic step(input int n);
        repeat (n) @(posedge clk1000);
        #1;
    endtask

    task automatic apply_stimulus(input logic st, input logic ld, input logic md, input logic [23:0] val);
        tif.start    = st;
        tif.load     = ld;
        tif.mode     = md;
        tif.load_val = val;
        step(1);
        tif.start = 1'b0;
        tif.load  = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic run_cycles(input int n, output int nticks);
        nticks = 0;
        repeat (n) begin
            step(1);
            if (tif.tick) nticks++;
        end
    endtask

    initial begin
        rst          = 1'b0;
        tif.start    = 1'b0;
        tif.mode     = 1'b0;
        tif.load     = 1'b0;
        tif.load_val = '0;

        // Reset held, then released: must sit in IDLE with no ticks.
        step(5);
        check_output("rst_bus", tif.bus, 24'h000000);
        check_output("rst_done", 24'(tif.done), 24'd0);
        check_output("rst_tick", 24'(tif.tick), 24'd0);
        rst = 1'b1;
        run_cycles(1010, ticks);
        check_output("idle_ticks", 24'(ticks), 24'd0);
        check_output("idle_bus", tif.bus, 24'h000000);

        // Count up across midnight.
        apply_stimulus(1'b0, 1'b1, 1'b0, 24'h173B3A);
        check_output("up_load", tif.bus, 24'h173B3A);
        apply_stimulus(1'b1, 1'b0, 1'b0, 24'h000000);
        ticks      = 0;
        first_tick = -1;
        for (int i = 1; i <= 2000; i++) begin
            step(1);
            if (tif.tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
            if (i == 1000) check_output("up_bus_1s", tif.bus, 24'h173B3B);
        end
        check_output("up_ticks", 24'(ticks), 24'd2);
        check_output("up_first_tick", 24'(first_tick), 24'd1000);
        check_output("up_last_tick", 24'(tif.tick), 24'd1);
        check_output("up_wrap_bus", tif.bus, 24'h000000);

        // Count down from 00:01:01 to zero.
        apply_stimulus(1'b0, 1'b1, 1'b1, 24'h000101);
        apply_stimulus(1'b1, 1'b0, 1'b1, 24'h000000);
        ticks = 0;
        for (int i = 1; i <= 61000; i++) begin
            step(1);
            if (tif.tick) ticks++;
            if (i == 1000)  check_output("dn_bus_1s", tif.bus, 24'h000100);
            if (i == 2000)  check_output("dn_bus_2s", tif.bus, 24'h00003B);
            if (i == 60999) begin
                check_output("dn_bus_60s", tif.bus, 24'h000001);
                check_output("dn_done_early", 24'(tif.done), 24'd0);
            end
        end
        check_output("dn_zero_bus", tif.bus, 24'h000000);
        check_output("dn_ticks", 24'(ticks), 24'd61);
        step(1);
        check_output("dn_done", 24'(tif.done), 24'd1);
        run_cycles(1500, ticks);
        check_output("dn_hold_ticks", 24'(ticks), 24'd0);
        check_output("dn_hold_bus", tif.bus, 24'h000000);
        check_output("dn_hold_done", 24'(tif.done), 24'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 24'h000000);
        check_output("dn_ack_done", 24'(tif.done), 24'd0);
        run_cycles(1010, ticks);
        check_output("dn_ack_idle", 24'(ticks), 24'd0);
        check_output("dn_ack_bus", tif.bus, 24'h000000);

        // Pause after 1.5 s keeps the half second already counted.
        apply_stimulus(1'b0, 1'b1, 1'b0, 24'h000000);
        apply_stimulus(1'b1, 1'b0, 1'b0, 24'h000000);
        run_cycles(1499, ticks);
        check_output("pz_ticks_pre", 24'(ticks), 24'd1);
        check_output("pz_bus_pre", tif.bus, 24'h000001);
        apply_stimulus(1'b1, 1'b0, 1'b0, 24'h000000);
        run_cycles(5000, ticks);
        check_output("pz_ticks_paused", 24'(ticks), 24'd0);
        check_output("pz_bus_paused", tif.bus, 24'h000001);
        apply_stimulus(1'b1, 1'b0, 1'b0, 24'h000000);
        first_tick = -1;
        for (int k = 1; k <= 1200; k++) begin
            step(1);
            if (tif.tick) begin
                first_tick = k;
                break;
            end
        end
        check_output("pz_resume_tick", 24'(first_tick), 24'd500);
        check_output("pz_bus_post", tif.bus, 24'h000002);

        // Load clamps each field and wins over a simultaneous start.
        apply_stimulus(1'b1, 1'b1, 1'b0, 24'h3F4A50);
        check_output("cl_bus", tif.bus, 24'h173B3B);
        check_output("cl_done", 24'(tif.done), 24'd0);
        run_cycles(1010, ticks);
        check_output("cl_idle_ticks", 24'(ticks), 24'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 24'h053C10);
        check_output("cl_mm_only", tif.bus, 24'h053B10);

        // Counting down from zero goes straight to DONE without a tick.
        apply_stimulus(1'b0, 1'b1, 1'b1, 24'h000000);
        apply_stimulus(1'b1, 1'b0, 1'b1, 24'h000000);
        check_output("z_done", 24'(tif.done), 24'd1);
        check_output("z_tick", 24'(tif.tick), 24'd0);
        run_cycles(1010, ticks);
        check_output("z_ticks", 24'(ticks), 24'd0);
        check_output("z_bus", tif.bus, 24'h000000);

        // Asynchronous reset in the middle of a second.
        apply_stimulus(1'b0, 1'b1, 1'b0, 24'h010203);
        apply_stimulus(1'b1, 1'b0, 1'b0, 24'h000000);
        step(700);
        #2 rst = 1'b0;
        #1;
        check_output("ar_bus", tif.bus, 24'h000000);
        check_output("ar_tick", 24'(tif.tick), 24'd0);
        check_output("ar_done", 24'(tif.done), 24'd0);
        step(3);
        rst = 1'b1;
        run_cycles(1010, ticks);
        check_output("ar_post_ticks", 24'(ticks), 24'd0);
        check_output("ar_post_bus", tif.bus, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
